// File: rtl/uc_pkg.sv
// Opcodes, FSM state encoding and opcode-class helpers
// shared by the stack/ULA sequencer and its bench.
package uc_pkg;

  localparam int UC_OP_W = 5;

  localparam logic [UC_OP_W-1:0] OP_NOP   = 5'h00;
  localparam logic [UC_OP_W-1:0] OP_PUSH  = 5'h01;
  localparam logic [UC_OP_W-1:0] OP_POP   = 5'h02;
  localparam logic [UC_OP_W-1:0] OP_ADD   = 5'h03;
  localparam logic [UC_OP_W-1:0] OP_SUB   = 5'h04;
  localparam logic [UC_OP_W-1:0] OP_MUL   = 5'h05;
  localparam logic [UC_OP_W-1:0] OP_DIV   = 5'h06;
  localparam logic [UC_OP_W-1:0] OP_AND   = 5'h07;
  localparam logic [UC_OP_W-1:0] OP_NAND  = 5'h08;
  localparam logic [UC_OP_W-1:0] OP_OR    = 5'h09;
  localparam logic [UC_OP_W-1:0] OP_XOR   = 5'h0A;
  localparam logic [UC_OP_W-1:0] OP_CMP   = 5'h0B;
  localparam logic [UC_OP_W-1:0] OP_NOT   = 5'h0C;
  localparam logic [UC_OP_W-1:0] OP_IF_EQ = 5'h0D;
  localparam logic [UC_OP_W-1:0] OP_IF_GT = 5'h0E;
  localparam logic [UC_OP_W-1:0] OP_IF_LT = 5'h0F;
  localparam logic [UC_OP_W-1:0] OP_IF_GE = 5'h10;
  localparam logic [UC_OP_W-1:0] OP_IF_LE = 5'h11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_LD_T2,
    S_LD_T1,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  function automatic logic is_binary(
    input logic [UC_OP_W-1:0] op
  );
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

  function automatic logic is_cmp(
    input logic [UC_OP_W-1:0] op
  );
    return (op >= OP_IF_EQ) && (op <= OP_IF_LE);
  endfunction

  function automatic logic is_legal(
    input logic [UC_OP_W-1:0] op
  );
    return op <= OP_IF_LE;
  endfunction

endpackage

// File: rtl/uc_depth_counter.sv
// Saturating stack-occupancy counter (0..STACK_DEPTH).
// Ports: up (+1), dn (0/1/2 down), depth, full/has1/has2.
module uc_depth_counter #(
  parameter int STACK_DEPTH = 16,
  parameter int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up,
  input  logic [1:0]    dn,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          has1,
  output logic          has2
);

  localparam logic [DW-1:0] MAX = DW'(STACK_DEPTH);

  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;
  logic [DW-1:0] dn_w;

  assign dn_w = DW'(dn);

  always_comb begin
    depth_d = depth_q;
    if (up) begin
      if (depth_q != MAX)
        depth_d = depth_q + DW'(1);
    end else if (dn != 2'd0) begin
      if (depth_q >= dn_w)
        depth_d = depth_q - dn_w;
      else
        depth_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  assign depth = depth_q;
  assign full  = (depth_q == MAX);
  assign has1  = (depth_q >= DW'(1));
  assign has2  = (depth_q >= DW'(2));

endmodule

// File: rtl/uc_sequenciador.sv
// Control unit sequencing the stack/temp/ULA datapath.
// Ports: instr_* handshake in, datapath strobes/status out.
module uc_sequenciador
  import uc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int OP_W        = 5,
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [OP_W-1:0]    instr_op,
  input  logic [DATA_W-1:0]  instr_imm,
  output logic               instr_ready,
  input  logic               flag_ula,
  output logic               wren,
  output logic               controle_pilha,
  output logic               clk_pilha,
  output logic               clk_temp1,
  output logic               clk_temp2,
  output logic               load_temp1,
  output logic               load_temp2,
  output logic [DATA_W-1:0]  din_UC,
  output logic [OP_W-1:0]    opcode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cond_true,
  output logic [DEPTH_W-1:0] depth
);

  state_e state_q, state_d;

  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              cond_q, cond_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
  logic              ctl_q, ctl_d;
  logic              pil_q, pil_d;
  logic              t1_q, t1_d;
  logic              t2_q, t2_d;

  logic       full, has1, has2;
  logic       accept, fault;
  logic       cnt_up, upd;
  logic [1:0] cnt_dn;

  uc_depth_counter #(
    .STACK_DEPTH (STACK_DEPTH),
    .DW          (DEPTH_W)
  ) u_depth (
    .clk   (clk),
    .reset (reset),
    .up    (cnt_up),
    .dn    (cnt_dn),
    .depth (depth),
    .full  (full),
    .has1  (has1),
    .has2  (has2)
  );

  // ready_q is the registered image of IDLE, so it
  // gates acceptance directly.
  assign accept = instr_valid && ready_q;

  always_comb begin
    fault = !is_legal(instr_op)
      || ((instr_op == OP_PUSH) && full)
      || (((instr_op == OP_POP)
        || (instr_op == OP_NOT)) && !has1)
      || ((is_binary(instr_op)
        || is_cmp(instr_op)) && !has2);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    cond_d  = cond_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = instr_op;
          imm_d = instr_imm;
          if (fault) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            unique case (1'b1)
              (instr_op == OP_PUSH): state_d = S_PUSH;
              (instr_op == OP_POP):  state_d = S_POP;
              (instr_op == OP_NOT):  state_d = S_LD_T1;
              (is_binary(instr_op)
                || is_cmp(instr_op)): state_d = S_LD_T2;
              default:               state_d = S_DONE;
            endcase
          end
        end
      end
      S_PUSH:  state_d = S_DONE;
      S_POP:   state_d = S_DONE;
      S_LD_T2: state_d = S_LD_T1;
      S_LD_T1: state_d = S_EXEC;
      S_EXEC: begin
        if (is_cmp(op_q)) begin
          cond_d  = flag_ula;
          state_d = S_DONE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
    endcase
  end

  // Depth moves on the edge into DONE so it is
  // already current while done is high. Entries
  // straight from IDLE are NOP or faults: no change.
  always_comb begin
    upd    = (state_d == S_DONE) && (state_q != S_IDLE);
    cnt_up = upd && (op_q == OP_PUSH);
    cnt_dn = 2'd0;
    if (upd) begin
      unique case (1'b1)
        (op_q == OP_POP):  cnt_dn = 2'd1;
        is_binary(op_q):   cnt_dn = 2'd1;
        is_cmp(op_q):      cnt_dn = 2'd2;
        default:           cnt_dn = 2'd0;
      endcase
    end
  end

  // Outputs decoded from the next state and registered,
  // so each strobe lines up with its state cycle.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    wren_d  = 1'b0;
    ctl_d   = 1'b0;
    pil_d   = 1'b0;
    t1_d    = 1'b0;
    t2_d    = 1'b0;
    unique case (state_d)
      S_PUSH: begin
        wren_d = 1'b1;
        pil_d  = 1'b1;
      end
      S_POP:   pil_d = 1'b1;
      S_LD_T2: begin
        pil_d = 1'b1;
        t2_d  = 1'b1;
      end
      S_LD_T1: begin
        pil_d = 1'b1;
        t1_d  = 1'b1;
      end
      S_WB: begin
        wren_d = 1'b1;
        ctl_d  = 1'b1;
        pil_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      cond_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      ctl_q   <= 1'b0;
      pil_q   <= 1'b0;
      t1_q    <= 1'b0;
      t2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      cond_q  <= cond_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
      ctl_q   <= ctl_d;
      pil_q   <= pil_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
    end
  end

  assign instr_ready    = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign cond_true      = cond_q;
  assign wren           = wren_q;
  assign controle_pilha = ctl_q;
  assign clk_pilha      = pil_q;
  assign clk_temp1      = t1_q;
  assign clk_temp2      = t2_q;
  assign load_temp1     = t1_q;
  assign load_temp2     = t2_q;
  assign din_UC         = imm_q;
  assign opcode         = op_q;

endmodule
